// File: rtl/cpt_updown_mod_pkg.sv
// cpt_updown_mod_pkg: shared direction and mode encodings for the compteur counters.
// Revision 1.0
`default_nettype none

package cpt_updown_mod_pkg;

  localparam logic CPT_UP   = 1'b1;
  localparam logic CPT_DOWN = 1'b0;
  localparam logic CPT_WRAP = 1'b1;
  localparam logic CPT_SAT  = 1'b0;

endpackage

`default_nettype wire

// File: rtl/cpt_next_val.sv
// cpt_next_val: combinational next-count and terminal detection for cpt_updown_mod.
// Revision 1.0
`default_nettype none

module cpt_next_val
  import cpt_updown_mod_pkg::*;
#(
  parameter int SIZE = 8,
  parameter bit WRAP = 1'b1
) (
  input  logic [SIZE-1:0] out_i,
  input  logic [SIZE-1:0] limit_i,
  input  logic            up_down_i,
  input  logic            load_i,
  input  logic [SIZE-1:0] load_val_i,
  input  logic            activate_i,
  output logic [SIZE-1:0] next_o,
  output logic            term_o
);

  logic w_term;
  logic w_above;

  assign w_term  = (up_down_i == CPT_UP) ? (out_i >= limit_i) : (out_i == '0);
  // A count above a freshly lowered limit is pulled back, not treated as terminal.
  assign w_above = (out_i > limit_i);
  assign term_o  = w_term;

  always_comb begin
    next_o = out_i;
    if (load_i) begin
      next_o = (load_val_i > limit_i) ? limit_i : load_val_i;
    end else if (activate_i) begin
      if (up_down_i == CPT_UP) begin
        if (w_term) begin
          next_o = (WRAP == CPT_WRAP) ? '0 : limit_i;
        end else begin
          next_o = out_i + SIZE'(1);
        end
      end else begin
        if (w_term) begin
          next_o = (WRAP == CPT_WRAP) ? limit_i : '0;
        end else if (w_above) begin
          next_o = limit_i;
        end else begin
          next_o = out_i - SIZE'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cpt_updown_mod.sv
// cpt_updown_mod: synchronous up/down modulo counter with load, wrap/saturate, tc and sticky ovf.
// Revision 1.0
`default_nettype none

module cpt_updown_mod
  import cpt_updown_mod_pkg::*;
#(
  parameter int SIZE    = 8,
  parameter bit WRAP    = 1'b1,
  parameter int RST_VAL = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            activate_i,
  input  logic            up_down_i,
  input  logic            load_i,
  input  logic [SIZE-1:0] load_val_i,
  input  logic [SIZE-1:0] limit_i,
  input  logic            clr_ovf_i,
  output logic [SIZE-1:0] out_o,
  output logic            tc_o,
  output logic            ovf_o
);

  localparam logic [SIZE-1:0] C_RST_VEC = SIZE'(RST_VAL);

  logic [SIZE-1:0] out_q;
  logic [SIZE-1:0] out_d;
  logic            ovf_q;
  logic            ovf_d;
  logic            w_term;
  logic            w_tc;

  cpt_next_val #(
    .SIZE (SIZE),
    .WRAP (WRAP)
  ) u_next (
    .out_i      (out_q),
    .limit_i    (limit_i),
    .up_down_i  (up_down_i),
    .load_i     (load_i),
    .load_val_i (load_val_i),
    .activate_i (activate_i),
    .next_o     (out_d),
    .term_o     (w_term)
  );

  assign w_tc = activate_i & ~load_i & ~reset & w_term;

  // Setting on tc takes precedence over a simultaneous clear request.
  always_comb begin
    ovf_d = ovf_q;
    if (w_tc) begin
      ovf_d = 1'b1;
    end else if (clr_ovf_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= C_RST_VEC;
      ovf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_o = out_q;
  assign tc_o  = w_tc;
  assign ovf_o = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_cpt_updown_mod.sv
// tb_cpt_updown_mod: directed scoreboard bench over three counter configurations.
// Revision 1.0
`default_nettype none

module tb_cpt_updown_mod;

  typedef struct {
    int    d;
    int    out;
    int    ovf;
    string tag;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Configuration A: SIZE=4, WRAP=1, RST_VAL=5
  logic       a_rst = 0, a_act = 0, a_up = 0, a_ld = 0, a_clr = 0;
  logic [3:0] a_lv = '0, a_lim = '0, a_out;
  logic       a_tc, a_ovf;
  // Configuration B: SIZE=4, WRAP=0, RST_VAL=0
  logic       b_rst = 0, b_act = 0, b_up = 0, b_ld = 0, b_clr = 0;
  logic [3:0] b_lv = '0, b_lim = '0, b_out;
  logic       b_tc, b_ovf;
  // Configuration C: SIZE=1, WRAP=1, RST_VAL=0
  logic       c_rst = 0, c_act = 0, c_up = 0, c_ld = 0, c_clr = 0;
  logic [0:0] c_lv = '0, c_lim = '0, c_out;
  logic       c_tc, c_ovf;

  cpt_updown_mod #(.SIZE(4), .WRAP(1'b1), .RST_VAL(5)) dut_a (
    .clk(clk), .reset(a_rst), .activate_i(a_act), .up_down_i(a_up), .load_i(a_ld),
    .load_val_i(a_lv), .limit_i(a_lim), .clr_ovf_i(a_clr),
    .out_o(a_out), .tc_o(a_tc), .ovf_o(a_ovf));

  cpt_updown_mod #(.SIZE(4), .WRAP(1'b0), .RST_VAL(0)) dut_b (
    .clk(clk), .reset(b_rst), .activate_i(b_act), .up_down_i(b_up), .load_i(b_ld),
    .load_val_i(b_lv), .limit_i(b_lim), .clr_ovf_i(b_clr),
    .out_o(b_out), .tc_o(b_tc), .ovf_o(b_ovf));

  cpt_updown_mod #(.SIZE(1), .WRAP(1'b1), .RST_VAL(0)) dut_c (
    .clk(clk), .reset(c_rst), .activate_i(c_act), .up_down_i(c_up), .load_i(c_ld),
    .load_val_i(c_lv), .limit_i(c_lim), .clr_ovf_i(c_clr),
    .out_o(c_out), .tc_o(c_tc), .ovf_o(c_ovf));

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];
  int   m_out[3];
  int   m_ovf[3];

  function automatic logic [31:0] get_out(input int d);
    case (d)
      0:       return {28'b0, a_out};
      1:       return {28'b0, b_out};
      default: return {31'b0, c_out};
    endcase
  endfunction

  function automatic logic [31:0] get_tc(input int d);
    case (d)
      0:       return {31'b0, a_tc};
      1:       return {31'b0, b_tc};
      default: return {31'b0, c_tc};
    endcase
  endfunction

  function automatic logic [31:0] get_ovf(input int d);
    case (d)
      0:       return {31'b0, a_ovf};
      1:       return {31'b0, b_ovf};
      default: return {31'b0, c_ovf};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // One clock of stimulus on configuration d, with tc checked before the edge
  // and the registered result checked through the scoreboard after it.
  task automatic step(input int d, input string tag, input bit rst, input bit act,
                      input bit up, input bit ld, input int lv, input int lim, input bit clr);
    exp_t e;
    int   msk, lv_c, lim_c, wrap, rstv, nxt, etc;
    msk   = (d == 2) ? 1 : 15;
    lv_c  = lv & msk;
    lim_c = lim & msk;
    wrap  = (d == 1) ? 0 : 1;
    rstv  = (d == 0) ? 5 : 0;
    @(negedge clk);
    case (d)
      0: begin a_rst = rst; a_act = act; a_up = up; a_ld = ld; a_lv = 4'(lv_c); a_lim = 4'(lim_c); a_clr = clr; end
      1: begin b_rst = rst; b_act = act; b_up = up; b_ld = ld; b_lv = 4'(lv_c); b_lim = 4'(lim_c); b_clr = clr; end
      default: begin c_rst = rst; c_act = act; c_up = up; c_ld = ld; c_lv = 1'(lv_c); c_lim = 1'(lim_c); c_clr = clr; end
    endcase
    #1;
    etc = (act && !ld && !rst && (up ? (m_out[d] >= lim_c) : (m_out[d] == 0))) ? 1 : 0;
    chk({tag, ":tc"}, get_tc(d), 32'(etc));
    if (rst)                     nxt = rstv;
    else if (ld)                 nxt = (lv_c < lim_c) ? lv_c : lim_c;
    else if (!act)               nxt = m_out[d];
    else if (up)                 nxt = (m_out[d] >= lim_c) ? (wrap ? 0 : lim_c) : m_out[d] + 1;
    else if (m_out[d] == 0)      nxt = wrap ? lim_c : 0;
    else if (m_out[d] > lim_c)   nxt = lim_c;
    else                         nxt = m_out[d] - 1;
    e.d   = d;
    e.out = nxt;
    e.ovf = rst ? 0 : (etc == 1) ? 1 : clr ? 0 : m_ovf[d];
    e.tag = tag;
    sb_q.push_back(e);
    m_out[d] = e.out;
    m_ovf[d] = e.ovf;
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({e.tag, ":out"}, get_out(e.d), 32'(e.out));
    chk({e.tag, ":ovf"}, get_ovf(e.d), 32'(e.ovf));
    case (d)
      0: begin a_rst = 0; a_act = 0; a_ld = 0; a_clr = 0; end
      1: begin b_rst = 0; b_act = 0; b_ld = 0; b_clr = 0; end
      default: begin c_rst = 0; c_act = 0; c_ld = 0; c_clr = 0; end
    endcase
  endtask

  initial begin
    m_out = '{0, 0, 0};
    m_ovf = '{0, 0, 0};

    // Configuration A: reset value, up wrap, reset priority, limit lowering, clamp
    step(0, "a_reset", 1, 0, 1, 0, 0, 9, 0);
    chk("a_rst_val", get_out(0), 32'd5);
    step(0, "a_load0", 0, 0, 1, 1, 0, 9, 0);
    for (int i = 0; i < 10; i++) step(0, $sformatf("a_up%0d", i), 0, 1, 1, 0, 0, 9, 0);
    chk("a_wrap_out", get_out(0), 32'd0);
    chk("a_wrap_ovf", get_ovf(0), 32'd1);
    step(0, "a_clr", 0, 0, 1, 0, 0, 9, 1);
    step(0, "a_load9", 0, 0, 1, 1, 9, 15, 0);
    step(0, "a_rst_mid", 1, 1, 1, 0, 0, 15, 0);
    step(0, "a_rst_ld", 1, 0, 1, 1, 3, 15, 0);
    chk("a_rst_wins", get_out(0), 32'd5);
    step(0, "a_load12u", 0, 0, 1, 1, 12, 15, 0);
    step(0, "a_lowlim_up", 0, 1, 1, 0, 0, 4, 0);
    step(0, "a_clr2", 0, 0, 1, 0, 0, 4, 1);
    step(0, "a_load12d", 0, 0, 0, 1, 12, 15, 0);
    step(0, "a_lowlim_dn", 0, 1, 0, 0, 0, 4, 0);
    chk("a_lowlim_dn_val", get_out(0), 32'd4);
    step(0, "a_clamp", 0, 1, 1, 1, 12, 6, 0);
    chk("a_clamp_val", get_out(0), 32'd6);
    step(0, "a_load3", 0, 0, 1, 1, 3, 6, 0);
    step(0, "a_lim0_ld", 0, 0, 1, 1, 0, 0, 0);
    step(0, "a_lim0_up", 0, 1, 1, 0, 0, 0, 0);
    step(0, "a_lim0_dn", 0, 1, 0, 0, 0, 0, 0);
    step(0, "a_lim0_up2", 0, 1, 1, 0, 0, 0, 0);
    step(0, "a_load7", 0, 0, 1, 1, 7, 15, 0);
    for (int i = 0; i < 5; i++) step(0, $sformatf("a_hold%0d", i), 0, 0, 1, 0, 0, 15, 0);
    chk("a_hold_val", get_out(0), 32'd7);

    // Configuration B: down saturation with clear held, then up saturation
    step(1, "b_reset", 1, 0, 0, 0, 0, 15, 0);
    step(1, "b_load2", 0, 0, 0, 1, 2, 15, 0);
    for (int i = 0; i < 4; i++) step(1, $sformatf("b_dn%0d", i), 0, 1, 0, 0, 0, 15, 1);
    chk("b_sat_out", get_out(1), 32'd0);
    chk("b_set_wins", get_ovf(1), 32'd1);
    step(1, "b_load14", 0, 0, 1, 1, 14, 15, 1);
    step(1, "b_up0", 0, 1, 1, 0, 0, 15, 0);
    step(1, "b_up1", 0, 1, 1, 0, 0, 15, 0);
    chk("b_sat_top", get_out(1), 32'd15);

    // Configuration C: single-bit counter toggling
    step(2, "c_reset", 1, 0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(2, $sformatf("c_up%0d", i), 0, 1, 1, 0, 0, 1, 0);
    chk("c_final", get_out(2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
